// File: rtl/snn_pkg.sv
// Shared SNN definitions: IMEM base addresses, spike-vector sizing, loader FSM
// state encoding and the spike-word select helper.
// No ports; imported by the loader (and by imem for the base addresses).
package snn_pkg;

   // Axon memory base per core. The same values are decoded by imem.
   localparam logic [31:0] IMEM_BASE_CORE0 = 32'h8000_0000;
   localparam logic [31:0] IMEM_BASE_CORE1 = 32'h8001_0000;

   // 256 axons per core, carried as 8 x 32-bit words.
   localparam int unsigned SPIKE_WORDS = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      GAP  = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } loader_state_t;

   // Word k is vec[255-32k -: 32]: word 0 is the most significant slice,
   // matching the concatenation order IMEM uses. The base of that slice is
   // (7-k)*32, which is simply {~k, 5'b0}.
   function automatic logic [31:0] spike_word(input logic [255:0] vec,
                                              input logic [2:0]   k);
      return vec[{~k, 5'b00000} +: 32];
   endfunction

endpackage

// File: rtl/spike_wb_loader.sv
// Wishbone initiator that writes a latched 256-bit spike vector into one
// core's IMEM as 8 single-word writes (REQ, then GAP, for each word), then
// pulses done_o, or pulses err_o if a word is not acknowledged in time.
// Ports: start_i/core_sel_i/spike_vec_i launch a load (sampled in IDLE only);
// busy_o/done_o/err_o report status; core_en_o is the one-hot IMEM core
// select; wbm_* is the Wishbone master port. All outputs are registered.
module spike_wb_loader
   import snn_pkg::*;
#(
   parameter logic [31:0] IMEM_BASE_0 = IMEM_BASE_CORE0,
   parameter logic [31:0] IMEM_BASE_1 = IMEM_BASE_CORE1,
   parameter int unsigned NUM_WORDS   = SPIKE_WORDS,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_ni,
   input  logic         start_i,
   input  logic         core_sel_i,
   input  logic [255:0] spike_vec_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic [1:0]   core_en_o,
   output logic         wbm_cyc_o,
   output logic         wbm_stb_o,
   output logic         wbm_we_o,
   output logic [3:0]   wbm_sel_o,
   output logic [31:0]  wbm_adr_o,
   output logic [31:0]  wbm_dat_o,
   input  logic         wbm_ack_i
);

   localparam int unsigned     TO_W   = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT);
   localparam logic [2:0]      K_LAST = 3'(NUM_WORDS - 1);

   loader_state_t   state_q;
   logic [2:0]      k_q;
   logic [TO_W-1:0] to_cnt_q;
   logic [255:0]    vec_q;
   logic [31:0]     base_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic            cyc_q;
   logic [1:0]      en_q;
   logic [31:0]     adr_q;
   logic [31:0]     dat_q;

   // Next-word values, prepared so the GAP->REQ edge can register them.
   logic [2:0]      k_d;
   logic [31:0]     adr_d;
   logic [31:0]     dat_d;
   logic [31:0]     base_d;

   always_comb begin
      k_d    = k_q + 3'd1;
      adr_d  = base_q + {27'd0, k_d, 2'b00};
      dat_d  = spike_word(vec_q, k_d);
      base_d = core_sel_i ? IMEM_BASE_1 : IMEM_BASE_0;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q  <= IDLE;
         k_q      <= 3'd0;
         to_cnt_q <= '0;
         vec_q    <= '0;
         base_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cyc_q    <= 1'b0;
         en_q     <= 2'b00;
         adr_q    <= '0;
         dat_q    <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q  <= REQ;
                  vec_q    <= spike_vec_i;
                  base_q   <= base_d;
                  k_q      <= 3'd0;
                  to_cnt_q <= '0;
                  busy_q   <= 1'b1;
                  en_q     <= core_sel_i ? 2'b10 : 2'b01;
                  cyc_q    <= 1'b1;
                  // vec_q is not loaded yet, so word 0 comes from the input.
                  adr_q    <= base_d;
                  dat_q    <= spike_word(spike_vec_i, 3'd0);
               end
            end
            REQ: begin
               if (wbm_ack_i) begin
                  state_q  <= GAP;
                  cyc_q    <= 1'b0;
                  to_cnt_q <= '0;
               end else if (to_cnt_q == TO_MAX) begin
                  // Counter stops here: ERR is entered instead of wrapping.
                  state_q <= ERR;
                  cyc_q   <= 1'b0;
                  err_q   <= 1'b1;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            GAP: begin
               // Ack is ignored here: the slave's registered ack lingers.
               if (k_q == K_LAST) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= REQ;
                  k_q     <= k_d;
                  adr_q   <= adr_d;
                  dat_q   <= dat_d;
                  cyc_q   <= 1'b1;
               end
            end
            DONE, ERR: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               en_q    <= 2'b00;
               adr_q   <= '0;
               dat_q   <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobe, write enable and byte lanes are all asserted exactly in REQ.
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign core_en_o = en_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = cyc_q;
   assign wbm_sel_o = {4{cyc_q}};
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_spike_wb_loader.sv
module tb_spike_wb_loader;
   import snn_pkg::*;

   localparam int HN = 4096;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic         core_sel_i = 1'b0;
   logic [255:0] spike_vec_i = '0;
   logic         busy_o, done_o, err_o;
   logic [1:0]   core_en_o;
   logic         cyc_o, stb_o, we_o;
   logic [3:0]   sel_o;
   logic [31:0]  adr_o, dat_o;
   logic         ack;

   spike_wb_loader dut (
      .wb_clk_i   (clk),
      .wb_rst_ni  (rst_n),
      .start_i    (start_i),
      .core_sel_i (core_sel_i),
      .spike_vec_i(spike_vec_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .core_en_o  (core_en_o),
      .wbm_cyc_o  (cyc_o),
      .wbm_stb_o  (stb_o),
      .wbm_we_o   (we_o),
      .wbm_sel_o  (sel_o),
      .wbm_adr_o  (adr_o),
      .wbm_dat_o  (dat_o),
      .wbm_ack_i  (ack)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   // ---------------- slave model: registered ack after ack_dly strobe cycles
   int ack_dly = 1;   // 0 = never acknowledge
   int stb_run = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack     <= 1'b0;
         stb_run <= 0;
      end else if (cyc_o && stb_o) begin
         ack     <= (ack_dly != 0) && (stb_run >= ack_dly - 1);
         stb_run <= stb_run + 1;
      end else begin
         ack     <= 1'b0;
         stb_run <= 0;
      end
   end

   typedef struct packed {
      logic [1:0]  en;
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   logic [31:0] mem [2][8];
   logic        mem_clr = 1'b0;
   int          bad_adr = 0;
   wr_t         wlog[$];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int c = 0; c < 2; c++)
            for (int w = 0; w < 8; w++) mem[c][w] <= '0;
      end else if (cyc_o && stb_o && we_o) begin
         if (core_en_o == 2'b01 && adr_o[31:5] == IMEM_BASE_CORE0[31:5])
            mem[0][adr_o[4:2]] <= dat_o;
         else if (core_en_o == 2'b10 && adr_o[31:5] == IMEM_BASE_CORE1[31:5])
            mem[1][adr_o[4:2]] <= dat_o;
         else
            bad_adr <= bad_adr + 1;
         if (ack) wlog.push_back('{en: core_en_o, adr: adr_o, dat: dat_o});
      end
   end

   // ---------------- cycle-indexed history, sampled mid-cycle
   int         edge_cnt = 0;
   logic       busy_h [HN];
   logic       cyc_h  [HN];
   logic       done_h [HN];
   logic       err_h  [HN];
   logic [1:0] en_h   [HN];
   int         sel_bad = 0;
   int         en_idle_bad = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(negedge clk) begin
      if (edge_cnt < HN) begin
         busy_h[edge_cnt] = busy_o;
         cyc_h[edge_cnt]  = cyc_o;
         done_h[edge_cnt] = done_o;
         err_h[edge_cnt]  = err_o;
         en_h[edge_cnt]   = core_en_o;
      end
      if (stb_o && sel_o != 4'hF) sel_bad++;
      if (!busy_o && core_en_o != 2'b00) en_idle_bad++;
   end

   function automatic int first_hit(input bit is_err, input int t0, input int span);
      for (int n = 0; n <= span; n++)
         if (t0 + n < HN && (is_err ? err_h[t0 + n] : done_h[t0 + n])) return n;
      return -1;
   endfunction

   function automatic int count_hits(input bit is_err, input int t0, input int span);
      int c;
      c = 0;
      for (int n = 0; n <= span; n++)
         if (t0 + n < HN && (is_err ? err_h[t0 + n] : done_h[t0 + n])) c++;
      return c;
   endfunction

   function automatic logic [255:0] mem_vec(input int c);
      logic [255:0] v;
      v = '0;
      for (int k = 0; k < 8; k++) v[255 - 32*k -: 32] = mem[c][k];
      return v;
   endfunction

   function automatic logic [75:0] all_outs();
      return {busy_o, done_o, err_o, core_en_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o};
   endfunction

   // All stimulus tasks start and end at posedge + 1.
   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      mem_clr = 1'b1;
      run(1);
      mem_clr = 1'b0;
   endtask

   // Cycle 0 is the cycle start_i is high; inputs are scrambled afterwards.
   task automatic launch(input logic core, input logic [255:0] v, output int t0);
      start_i     = 1'b1;
      core_sel_i  = core;
      spike_vec_i = v;
      t0          = edge_cnt;
      run(1);
      start_i     = 1'b0;
      core_sel_i  = ~core;
      spike_vec_i = ~v;
   endtask

   initial begin
      int           t0;
      int           n0;
      int           bad;
      logic [255:0] va, vb, vd, ve;

      va = 256'h01234567_89ABCDEF_FEDCBA98_76543210_00112233_44556677_8899AABB_CCDDEEFF;
      vb = 256'hDEADBEEF_00000000_11111111_22222222_33333333_44444444_55555555_66666666;
      vd = 256'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0_CAFEF00D_0BADC0DE;
      ve = 256'h10000001_20000002_30000003_40000004_50000005_60000006_70000007_80000008;

      // ---- reset
      run(3);
      check_eq("rst_outs_in_reset", all_outs(), '0);
      rst_n = 1'b1;
      run(2);
      check_eq("rst_outs_after", all_outs(), '0);

      // ---- core 0 load, one-cycle-ack slave
      clear_mem();
      n0 = wlog.size();
      launch(1'b0, va, t0);
      run(40);
      check_eq("c0_done_cycle", first_hit(1'b0, t0, 41), 25);
      check_eq("c0_done_count", count_hits(1'b0, t0, 41), 1);
      check_eq("c0_busy_c0", busy_h[t0], 1'b0);
      check_eq("c0_busy_c1", busy_h[t0 + 1], 1'b1);
      check_eq("c0_busy_c25", busy_h[t0 + 25], 1'b1);
      check_eq("c0_busy_c26", busy_h[t0 + 26], 1'b0);
      check_eq("c0_mem0", mem_vec(0), va);
      check_eq("c0_mem1", mem_vec(1), '0);
      check_eq("c0_nwrites", wlog.size() - n0, 8);
      check_eq("c0_word0", wlog[n0], {2'b01, 32'h8000_0000, 32'h0123_4567});
      check_eq("c0_word7", wlog[n0 + 7], {2'b01, 32'h8000_001C, 32'hCCDD_EEFF});

      // ---- core 1 load, only bit 0 set
      clear_mem();
      n0 = wlog.size();
      launch(1'b1, 256'h1, t0);
      run(40);
      check_eq("c1_done_cycle", first_hit(1'b0, t0, 41), 25);
      check_eq("c1_last_write", wlog[n0 + 7], {2'b10, 32'h8001_001C, 32'h0000_0001});
      check_eq("c1_mem1", mem_vec(1), 256'h1);
      check_eq("c1_mem0", mem_vec(0), '0);
      bad = 0;
      for (int n = 1; n <= 25; n++) if (en_h[t0 + n] !== 2'b10) bad++;
      check_eq("c1_core_en_busy", bad, 0);
      check_eq("c1_core_en_after", en_h[t0 + 26], 2'b00);

      // ---- ack timeout
      ack_dly = 0;
      launch(1'b0, vb, t0);
      run(30);
      check_eq("to_err_cycle", first_hit(1'b1, t0, 31), 18);
      check_eq("to_err_count", count_hits(1'b1, t0, 31), 1);
      check_eq("to_no_done", count_hits(1'b0, t0, 31), 0);
      check_eq("to_cyc_c17", cyc_h[t0 + 17], 1'b1);
      check_eq("to_cyc_c18", cyc_h[t0 + 18], 1'b0);
      check_eq("to_busy_c18", busy_h[t0 + 18], 1'b1);
      check_eq("to_busy_c19", busy_h[t0 + 19], 1'b0);
      ack_dly = 1;

      // ---- start while busy at cycle 10
      clear_mem();
      n0 = wlog.size();
      launch(1'b0, va, t0);
      run(9);
      start_i     = 1'b1;
      core_sel_i  = 1'b1;
      spike_vec_i = vb;
      run(1);
      start_i     = 1'b0;
      run(35);
      check_eq("sb_done_cycle", first_hit(1'b0, t0, 46), 25);
      check_eq("sb_done_count", count_hits(1'b0, t0, 46), 1);
      check_eq("sb_mem0", mem_vec(0), va);
      check_eq("sb_mem1", mem_vec(1), '0);
      check_eq("sb_nwrites", wlog.size() - n0, 8);

      // ---- reset in the middle of a transfer
      launch(1'b1, vb, t0);
      run(11);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mr_outs_async", all_outs(), '0);
      run(2);
      rst_n = 1'b1;
      run(1);
      clear_mem();
      n0 = wlog.size();
      launch(1'b0, vd, t0);
      run(40);
      check_eq("mr_reload_done", first_hit(1'b0, t0, 41), 25);
      check_eq("mr_reload_mem0", mem_vec(0), vd);
      check_eq("mr_reload_nwrites", wlog.size() - n0, 8);

      // ---- slow slave: ack three cycles after the first strobe cycle
      ack_dly = 3;
      clear_mem();
      n0 = wlog.size();
      launch(1'b1, ve, t0);
      run(50);
      check_eq("sl_done_cycle", first_hit(1'b0, t0, 51), 41);
      check_eq("sl_mem1", mem_vec(1), ve);
      check_eq("sl_nwrites", wlog.size() - n0, 8);
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         if (wlog[n0 + k].adr !== 32'h8001_0000 + 32'(4 * k)) bad++;
         if (wlog[n0 + k].dat !== ve[255 - 32*k -: 32]) bad++;
      end
      check_eq("sl_write_order", bad, 0);
      ack_dly = 1;

      // ---- whole-run bus properties
      check_eq("bus_sel_full", sel_bad, 0);
      check_eq("bus_core_en_idle", en_idle_bad, 0);
      check_eq("bus_addr_decode", bad_adr, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spike_wb_loader.md
# spike_wb_loader

Wishbone initiator that pushes a 256-bit input-spike vector into one core's axon memory (`imem`). On `start_i` it latches the vector and target core, then issues 8 single-word, full-byte-lane write cycles to that core's IMEM base. It sits between the spike source (host-side sequencer or test harness) and the IMEM Wishbone slave port, and drives the IMEM `core_en_i` select alongside the bus.

## Interface
- `IMEM_BASE_0`, default 32'h80000000: core-0 axon memory base address.
- `IMEM_BASE_1`, default 32'h80010000: core-1 axon memory base address.
- `NUM_WORDS`, default 8: 32-bit words per spike vector; fixed at 8 for a 256-axon core.
- `ACK_TIMEOUT`, default 16: maximum cycles to wait for `wbm_ack_i` per word.
- `wb_clk_i`, in, 1: the single clock.
- `wb_rst_ni`, in, 1: reset, asynchronous and active-low.
- `start_i`, in, 1: launch request; sampled only in IDLE.
- `core_sel_i`, in, 1: target core (0 or 1), latched at start.
- `spike_vec_i`, in, 256: spike vector, latched at start.
- `busy_o`, out, 1: high from the cycle after start is accepted through DONE/ERR inclusive.
- `done_o`, out, 1: one-cycle pulse after all 8 words are acknowledged.
- `err_o`, out, 1: one-cycle pulse on ack timeout.
- `core_en_o`, out, 2: one-hot select, `2'b01` for core 0 and `2'b10` for core 1; nonzero only while `busy_o` is high.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`, out, 1 each: Wishbone cycle, strobe and write enable.
- `wbm_sel_o`, out, 4: byte-lane selects; always `4'hF` during REQ.
- `wbm_adr_o`, out, 32: `base + 4*k`.
- `wbm_dat_o`, out, 32: data for word k.
- `wbm_ack_i`, in, 1: slave acknowledge.

## Operation
- **Reset values:** all outputs 0; state IDLE; word index and timeout counter 0.
- **States:** IDLE, REQ, GAP, DONE, ERR.
- **IDLE:** when `start_i` is high, latch `spike_vec_i`, `core_sel_i` and base address, set k=0, and go to REQ.
- **REQ:** drive `cyc` = `stb` = `we` = 1, `sel` = F, and the address and data for word k.
  - If `wbm_ack_i` is high, go to GAP and clear the timeout counter.
  - Otherwise increment the timeout counter. When it reaches `ACK_TIMEOUT`, go to ERR.
- **GAP:** `cyc` and `stb` are 0. `wbm_ack_i` is ignored here, because the slave's registered ack lingers one cycle.
  - If k=7, go to DONE.
  - Otherwise set k=k+1 and go to REQ.
- **DONE:** `done_o`=1, then IDLE.
- **ERR:** `err_o`=1 with bus idle, then IDLE. The partial transfer is not retried.
- **Word mapping:** word k carries `spike_vec[255-32k -: 32]`. Word 0 (bits 255:224) goes to base+0; word 7 (bits 31:0) goes to base+28. This matches the IMEM concatenation order.
- **Re-strobe:** the slave may see `stb` for two edges per word and rewrite the same data. This is harmless and accepted.
- **Start while busy:** `start_i` outside IDLE is ignored, with no queuing.
- **Input stability:** input changes after acceptance do not affect the running transfer.
- **Reset mid-transfer:** outputs drop to 0 immediately (asynchronous). Any partial IMEM contents are left as-is.
- **Width rules:**
  - k is 3 bits.
  - The timeout counter is `$clog2(ACK_TIMEOUT+1)` bits and saturates.
  - Address is computed as `base + {k,2'b00}` in 32 bits.

## Timing
- Start is accepted at the edge ending cycle 0. Word k is in REQ at cycle 1+3k, sees ack at 2+3k, and is in GAP at 3+3k. This assumes a one-cycle-ack slave.
- Against `imem`, `done_o` is high in cycle 25 and the block is back in IDLE in cycle 26. `busy_o` is high in cycles 1–25.
- A slave with longer ack latency stretches only REQ.
- A timeout starting at REQ cycle t gives `err_o` in cycle t+`ACK_TIMEOUT`+1.
- `start_i` asserted in the DONE cycle is ignored. It is accepted in the following IDLE cycle.

## Structure
- A shared package `snn_pkg` holds:
  - the IMEM base constants (shared with `imem`);
  - the state enum `loader_state_t` (IDLE, REQ, GAP, DONE, ERR);
  - the constant `SPIKE_WORDS`=8.
- Single module, no sub-modules. Word selection is a mux on k over the latched 256-bit register.

## Test plan
- **Core 0 load:** `spike_vec_i`=256'h0123…EF (distinct words), core 0, against `imem` → IMEM `spike_axon_0_o` equals the vector; `done_o` in cycle 25; `spike_axon_1_o` stays 0.
- **Core 1 load:** core 1, vector with only bit 0 set → a write of 32'h00000001 to 0x8001001C; `core_en_o`=2'b10 throughout.
- **Timeout:** slave never acks, `ACK_TIMEOUT`=16 → `err_o` pulses in cycle 18; `cyc`/`stb` low from cycle 18; no `done_o`.
- **Start while busy:** second `start_i` with a different vector at cycle 10 → ignored; the first vector is written intact and only one `done_o` occurs.
- **Reset mid-transfer:** `wb_rst_ni` low at cycle 12 → all outputs 0 within the same cycle (async); the next start performs a full 8-word load.
- **Slow slave:** ack delayed 3 cycles per word → 8 words written in order at base+0…28; `done_o` in cycle 41.
